// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : shared encodings, state type and special-case helper for the MDU
// Rev 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    localparam int          MDU_STEPS    = 32;
    localparam logic [31:0] MDU_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] MDU_ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mduState_t;

    // Fixed results for divide-by-zero and signed overflow; op[1] selects remainder.
    function automatic logic [31:0] mduSpecial(input logic [2:0]  op,
                                               input logic [31:0] dividend,
                                               input logic        divZero);
        logic [31:0] res;
        if (divZero) res = op[1] ? dividend : MDU_ALL_ONES;
        else         res = op[1] ? 32'd0    : MDU_INT_MIN;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// mdu_step : one combinational shift-add multiply / restoring divide iteration
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv,
    input  logic [2*WIDTH-1:0]   accIn,
    input  logic [WIDTH:0]       remIn,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   accOut,
    output logic [WIDTH:0]       remOut,
    output logic                 qBit
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_diff;

    always_comb begin
        accOut    = accIn;
        remOut    = remIn;
        qBit      = 1'b0;
        w_sum     = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
        // Partial remainder is always below the divisor, so bit WIDTH+1 of the
        // difference is a reliable borrow.
        w_shifted = {remIn, accIn[WIDTH-1]};
        w_diff    = w_shifted - {2'b00, operand};
        if (isDiv) begin
            qBit   = ~w_diff[WIDTH+1];
            remOut = qBit ? w_diff[WIDTH:0] : w_shifted[WIDTH:0];
            accOut = {accIn[2*WIDTH-2:0], 1'b0};
        end else begin
            accOut = {w_sum, accIn[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_iterative.sv
// ============================================================================
// mdu_iterative : 32-step iterative RV32M multiply/divide with one write-back beat
// Optional macro MDU_EARLY_OUT_EN: divide-by-zero / signed-overflow skip CALC.
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int ADDRSIZE = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                flush,
    input  logic [2:0]          funct3,
    input  logic [WORDSIZE-1:0] rs1Data,
    input  logic [WORDSIZE-1:0] rs2Data,
    input  logic [ADDRSIZE-1:0] rdIn,
    output logic                busy,
    output logic                regWrite,
    output logic [ADDRSIZE-1:0] writeReg,
    output logic [WORDSIZE-1:0] writeData
);

    mduState_t             r_state, w_nextState;
    logic [2:0]            r_op;
    logic [ADDRSIZE-1:0]   r_rd, r_writeReg;
    logic [2*WORDSIZE-1:0] r_acc, w_accNext, w_accFull, w_prod;
    logic [WORDSIZE:0]     r_rem, w_remNext;
    logic [WORDSIZE-1:0]   r_operand, r_writeData;
    logic [WORDSIZE-1:0]   w_absA, w_absB, w_quot, w_remFix, w_result;
    logic [4:0]            r_count;
    logic                  r_signA, r_signB, r_divZero, r_ovf;
    logic                  w_signA, w_signB, w_signedA, w_signedB;
    logic                  w_divZero, w_ovf, w_last, w_qBit, w_accept;

    assign w_signedA = (funct3 == MDU_MUL) || (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU)
                    || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
    assign w_signedB = (funct3 == MDU_MUL) || (funct3 == MDU_MULH)
                    || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
    assign w_signA   = w_signedA & rs1Data[WORDSIZE-1];
    assign w_signB   = w_signedB & rs2Data[WORDSIZE-1];
    assign w_absA    = w_signA ? -rs1Data : rs1Data;
    assign w_absB    = w_signB ? -rs2Data : rs2Data;
    assign w_divZero = funct3[2] && (rs2Data == '0);
    assign w_ovf     = ((funct3 == MDU_DIV) || (funct3 == MDU_REM))
                    && (rs1Data == MDU_INT_MIN) && (rs2Data == MDU_ALL_ONES);
    assign w_accept  = (r_state == IDLE) && start && !flush;
    assign w_last    = (r_count == 5'(MDU_STEPS - 1));

    mdu_step #(.WIDTH(WORDSIZE)) u_step (
        .isDiv   (r_op[2]),
        .accIn   (r_acc),
        .remIn   (r_rem),
        .operand (r_operand),
        .accOut  (w_accNext),
        .remOut  (w_remNext),
        .qBit    (w_qBit)
    );

    assign w_accFull = w_accNext | {{(2*WORDSIZE-1){1'b0}}, w_qBit};

    // Sign fixup and result selection for the final step.
    always_comb begin
        w_prod   = (r_signA ^ r_signB) ? -w_accFull : w_accFull;
        w_quot   = (r_signA ^ r_signB) ? -w_accFull[WORDSIZE-1:0] : w_accFull[WORDSIZE-1:0];
        w_remFix = r_signA ? -w_remNext[WORDSIZE-1:0] : w_remNext[WORDSIZE-1:0];
        w_result = '0;
        if (!r_op[2]) begin
            w_result = (r_op == MDU_MUL) ? w_prod[WORDSIZE-1:0] : w_prod[2*WORDSIZE-1:WORDSIZE];
        end else if (r_divZero || r_ovf) begin
            w_result = mduSpecial(r_op, w_remFix, r_divZero);
        end else begin
            w_result = r_op[1] ? w_remFix : w_quot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        busy        = (r_state != IDLE);
        regWrite    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef MDU_EARLY_OUT_EN
                    w_nextState = (w_divZero || w_ovf) ? DONE : CALC;
`else
                    w_nextState = CALC;
`endif
                end
            end
            CALC: begin
                if (flush)       w_nextState = IDLE;
                else if (w_last) w_nextState = DONE;
            end
            DONE: begin
                regWrite    = !flush;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_rd        <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_operand   <= '0;
            r_count     <= '0;
            r_signA     <= 1'b0;
            r_signB     <= 1'b0;
            r_divZero   <= 1'b0;
            r_ovf       <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
        end else if (w_accept) begin
            r_op      <= funct3;
            r_rd      <= rdIn;
            // Multiply keeps the multiplier in the low half; divide shifts the dividend out of it.
            r_acc     <= funct3[2] ? {{WORDSIZE{1'b0}}, w_absA} : {{WORDSIZE{1'b0}}, w_absB};
            r_operand <= funct3[2] ? w_absB : w_absA;
            r_rem     <= '0;
            r_count   <= '0;
            r_signA   <= w_signA;
            r_signB   <= w_signB;
            r_divZero <= w_divZero;
            r_ovf     <= w_ovf;
`ifdef MDU_EARLY_OUT_EN
            if (w_divZero || w_ovf) begin
                r_writeReg  <= rdIn;
                r_writeData <= mduSpecial(funct3, rs1Data, w_divZero);
            end
`endif
        end else if ((r_state == CALC) && !flush) begin
            r_acc   <= w_accFull;
            r_rem   <= w_remNext;
            r_count <= r_count + 5'd1;
            if (w_last) begin
                r_writeReg  <= r_rd;
                r_writeData <= w_result;
            end
        end
    end

    assign writeReg  = r_writeReg;
    assign writeData = r_writeData;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
// ============================================================================
// tb_mdu_iterative : scoreboard bench for mdu_iterative with arithmetic reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1Data = '0;
    logic [31:0] rs2Data = '0;
    logic [4:0]  rdIn = '0;
    logic        busy, regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          when;
    } exp_t;

    exp_t sbq[$];
    exp_t monItem;

    mdu_iterative #(.WORDSIZE(32), .ADDRSIZE(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .funct3    (funct3),
        .rs1Data   (rs1Data),
        .rs2Data   (rs2Data),
        .rdIn      (rdIn),
        .busy      (busy),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        if (op[2] && ((b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`endif
        return 33;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycle(input int c);
        while (cyc < c) stepCycle();
    endtask

    // Called 1 time unit after a rising edge; returns the cycle in which start was high.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit expectWb, output int when);
        int   n;
        exp_t e;
        n = 0;
        while (busy && n < 100) begin
            stepCycle();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL issue_wait: busy=%0b after %0d cycles, required 0", busy, n);
        end
        funct3  = op;
        rs1Data = a;
        rs2Data = b;
        rdIn    = rd;
        start   = 1'b1;
        when    = cyc;
        if (expectWb) begin
            e.rd   = rd;
            e.data = refModel(op, a, b);
            e.when = cyc + latency(op, a, b);
            sbq.push_back(e);
        end
        stepCycle();
        start   = 1'b0;
        rs1Data = $urandom;
        rs2Data = $urandom;
        rdIn    = 5'($urandom);
        funct3  = 3'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst_n && regWrite) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb: writeReg=%0d writeData=%h, required no write-back", writeReg, writeData);
            end else begin
                monItem = sbq.pop_front();
                check("wb_data",  writeData, monItem.data);
                check("wb_reg",   writeReg,  monItem.rd);
                check("wb_cycle", cyc,       monItem.when);
            end
        end
    end

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  dOp [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] dA  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] dB  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};

    initial begin
        int s, s2, n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      busy,      0);
        check("rst_regWrite",  regWrite,  0);
        check("rst_writeReg",  writeReg,  0);
        check("rst_writeData", writeData, 0);
        rst_n = 1'b1;
        stepCycle();

        // MUL 7 x -3 to x5 with busy timing around completion.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, s);
        waitCycle(s + 33);
        check("busy_in_done", busy, 1);
        waitCycle(s + 34);
        check("busy_after_done", busy, 0);

        for (int i = 1; i < 12; i++) issue(dOp[i], dA[i], dB[i], 5'(i + 1), 1'b1, s);

        // Flush a divide mid-calculation, then start a multiply right away.
        issue(3'd4, 32'd100, 32'd3, 5'd9, 1'b0, s);
        waitCycle(s + 10);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        issue(3'd0, 32'd6, 32'd7, 5'd11, 1'b1, s2);
        check("restart_cycle", s2, s + 11);

        // A start pulse during CALC must be ignored.
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1'b1, s);
        waitCycle(s + 5);
        funct3  = 3'd5;
        rs1Data = 32'd99;
        rs2Data = 32'd4;
        rdIn    = 5'd13;
        start   = 1'b1;
        stepCycle();
        start   = 1'b0;
        check("busy_ignore_start", busy, 1);

        // Randomized mix including x0 destinations and special operands.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 5'($urandom_range(0, 31)), 1'b1, s);
        end

        // Asynchronous reset mid-operation.
        issue(3'd4, 32'd1234, 32'd5, 5'd7, 1'b0, s);
        waitCycle(s + 20);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy",      busy,      0);
        check("arst_regWrite",  regWrite,  0);
        check("arst_writeReg",  writeReg,  0);
        check("arst_writeData", writeData, 0);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        issue(3'd7, 32'd100, 32'd7, 5'd3, 1'b1, s);

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            stepCycle();
            n++;
        end
        stepCycle();
        check("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
